// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and the default 640x480@60 constants.
// Used by vga_axis_counter and vga_timing_gen.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // One display axis, ordered as it is scanned: visible, front porch, sync, back porch.
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_axis_t;

  function automatic int axis_total(vga_axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

  localparam vga_axis_t DEF_H_AXIS = '{active: DEF_H_ACTIVE, fp: DEF_H_FP,
                                       sync: DEF_H_SYNC, bp: DEF_H_BP};
  localparam vga_axis_t DEF_V_AXIS = '{active: DEF_V_ACTIVE, fp: DEF_V_FP,
                                       sync: DEF_V_SYNC, bp: DEF_V_BP};

endpackage

// File: rtl/vga_axis_counter.sv
// Position counter for one VGA axis with terminal-count, visible-region
// and sync-window flags decoded combinationally from the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter vga_axis_t AXIS = DEF_H_AXIS,
  parameter int        W    = $clog2(axis_total(AXIS))
) (
  input  logic         clk50,
  input  logic         reset,
  input  logic         clear,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         active,
  output logic         in_sync
);

  localparam logic [W-1:0] LAST       = W'(axis_total(AXIS) - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(AXIS.active);
  localparam logic [W-1:0] SYNC_FIRST = W'(AXIS.active + AXIS.fp);
  localparam logic [W-1:0] SYNC_LAST  = W'(AXIS.active + AXIS.fp + AXIS.sync - 1);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (step) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

  assign tc      = (count == LAST);
  assign active  = (count < ACTIVE_END);
  assign in_sync = (count >= SYNC_FIRST) && (count <= SYNC_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider from clk50, h/v counters, sync/blank pins and strobes.
// Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic                                              clk50,
  input  logic                                              reset,
  input  logic                                              enable,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]      hcount,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]      vcount,
  output logic                                              vga_clk,
  output logic                                              vga_hs,
  output logic                                              vga_vs,
  output logic                                              vga_blank_n,
  output logic                                              vga_sync_n,
  output logic                                              pix_en,
  output logic                                              line_start,
  output logic                                              frame_start,
  output logic                                              vblank_start,
  output logic [15:0]                                       frame_cnt
);

  localparam vga_axis_t H_AXIS = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_axis_t V_AXIS = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int HCW = $clog2(axis_total(H_AXIS));
  localparam int VCW = $clog2(axis_total(V_AXIS));
  localparam int DW  = $clog2(CLK_DIV);

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [VCW-1:0] V_BLANK  = VCW'(V_ACTIVE);
  localparam logic           HS_ON    = 1'(HS_POL);
  localparam logic           VS_ON    = 1'(VS_POL);

  logic [DW-1:0] div_cnt;
  logic          h_tc, h_active, h_sync;
  logic          v_tc, v_active, v_sync;
  logic          run;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign pix_en = enable && (div_cnt == DIV_LAST);

  vga_axis_counter #(.AXIS(H_AXIS), .W(HCW)) u_h_axis (
    .clk50   (clk50),
    .reset   (reset),
    .clear   (!enable),
    .step    (pix_en),
    .count   (hcount),
    .tc      (h_tc),
    .active  (h_active),
    .in_sync (h_sync)
  );

  vga_axis_counter #(.AXIS(V_AXIS), .W(VCW)) u_v_axis (
    .clk50   (clk50),
    .reset   (reset),
    .clear   (!enable),
    .step    (pix_en && h_tc),
    .count   (vcount),
    .tc      (v_tc),
    .active  (v_active),
    .in_sync (v_sync)
  );

  // Outputs are masked by reset too, so the pins are safe before any edge arrives.
  assign run          = enable && !reset;
  assign vga_clk      = (div_cnt >= DIV_HALF);
  assign vga_hs       = (run && h_sync) ? HS_ON : ~HS_ON;
  assign vga_vs       = (run && v_sync) ? VS_ON : ~VS_ON;
  assign vga_sync_n   = vga_vs;
  assign vga_blank_n  = run && h_active && v_active;
  assign line_start   = run && (hcount == '0) && (div_cnt == '0);
  assign frame_start  = line_start && (vcount == '0);
  assign vblank_start = line_start && (vcount == V_BLANK);

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (pix_en && h_tc && v_tc) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  logic unused_v_tc;
  assign unused_v_tc = v_tc;
  assign frame_cnt   = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, tiny-raster instance
// (CLK_DIV=4, HS_POL=1, 14x10 raster) for frame, enable and reset behaviour.
module tb_vga_timing_gen;

  logic clk50 = 1'b0;
  logic reset;
  logic enable;

  logic [9:0]  hcount_d, vcount_d;
  logic        vga_clk_d, vga_hs_d, vga_vs_d, vga_blank_n_d, vga_sync_n_d;
  logic        pix_en_d, line_start_d, frame_start_d, vblank_start_d;
  logic [15:0] frame_cnt_d;

  logic [3:0]  hcount_s, vcount_s;
  logic        vga_clk_s, vga_hs_s, vga_vs_s, vga_blank_n_s, vga_sync_n_s;
  logic        pix_en_s, line_start_s, frame_start_s, vblank_start_s;
  logic [15:0] frame_cnt_s;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #10 clk50 = ~clk50;

  vga_timing_gen dut_d (
    .clk50(clk50), .reset(reset), .enable(enable),
    .hcount(hcount_d), .vcount(vcount_d),
    .vga_clk(vga_clk_d), .vga_hs(vga_hs_d), .vga_vs(vga_vs_d),
    .vga_blank_n(vga_blank_n_d), .vga_sync_n(vga_sync_n_d),
    .pix_en(pix_en_d), .line_start(line_start_d), .frame_start(frame_start_d),
    .vblank_start(vblank_start_d), .frame_cnt(frame_cnt_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(4), .HS_POL(1), .VS_POL(0)
  ) dut_s (
    .clk50(clk50), .reset(reset), .enable(enable),
    .hcount(hcount_s), .vcount(vcount_s),
    .vga_clk(vga_clk_s), .vga_hs(vga_hs_s), .vga_vs(vga_vs_s),
    .vga_blank_n(vga_blank_n_s), .vga_sync_n(vga_sync_n_s),
    .pix_en(pix_en_s), .line_start(line_start_s), .frame_start(frame_start_s),
    .vblank_start(vblank_start_s), .frame_cnt(frame_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clk50 edge, then sample 1 ns later; cyc counts edges since the last restart.
  task automatic tick();
    @(posedge clk50);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) tick();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    #5;
    check("rst_hcount_s", hcount_s, 0);
    check("rst_hs_s",     vga_hs_s, 0);
    check("rst_vs_s",     vga_vs_s, 1);
    check("rst_hs_d",     vga_hs_d, 1);
    check("rst_sync_n_d", vga_sync_n_d, 1);
    check("rst_blank_s",  vga_blank_n_s, 0);
    check("rst_fstart_s", frame_start_s, 0);
    check("rst_fcnt_s",   frame_cnt_s, 0);

    @(posedge clk50);
    #1;
    reset = 1'b0;
    cyc   = 0;
    #1;
    // First cycle after release: both rasters sit at pixel (0,0), phase 0.
    check("k0_lstart_s",  line_start_s, 1);
    check("k0_fstart_s",  frame_start_s, 1);
    check("k0_vbstart_s", vblank_start_s, 0);
    check("k0_pix_en_s",  pix_en_s, 0);
    check("k0_blank_s",   vga_blank_n_s, 1);
    check("k0_vclk_d",    vga_clk_d, 0);
    check("k0_fstart_d",  frame_start_d, 1);

    goto(1);
    check("k1_vclk_d",   vga_clk_d, 1);
    check("k1_pix_en_d", pix_en_d, 1);
    check("k1_lstart_d", line_start_d, 0);
    check("k1_vclk_s",   vga_clk_s, 0);
    goto(2);
    check("k2_vclk_d",   vga_clk_d, 0);
    check("k2_hcount_d", hcount_d, 1);
    check("k2_vclk_s",   vga_clk_s, 1);
    check("k2_pix_en_s", pix_en_s, 0);
    goto(3);
    check("k3_pix_en_s", pix_en_s, 1);
    check("k3_hcount_s", hcount_s, 0);
    goto(4);
    check("k4_hcount_s", hcount_s, 1);
    check("k4_vclk_s",   vga_clk_s, 0);

    // Small raster: visible h 0..7, hsync (active high) h 10..12.
    goto(31);  check("h7_blank_s",  vga_blank_n_s, 1);
    goto(32);  check("h8_blank_s",  vga_blank_n_s, 0);
    goto(39);  check("h9_hs_s",     vga_hs_s, 0);
    goto(40);  check("h10_hs_s",    vga_hs_s, 1);
    goto(51);  check("h12_hs_s",    vga_hs_s, 1);
    goto(52);  check("h13_hs_s",    vga_hs_s, 0);
    goto(55);
    check("h13_hcount_s", hcount_s, 13);
    check("h13_pix_en_s", pix_en_s, 1);
    goto(56);
    check("line1_hcount_s", hcount_s, 0);
    check("line1_vcount_s", vcount_s, 1);
    check("line1_lstart_s", line_start_s, 1);
    check("line1_fstart_s", frame_start_s, 0);

    // Small raster vertical: visible v 0..5, vblank_start at v=6, vsync (low) v 7..8.
    goto(335); check("v5_vcount_s",  vcount_s, 5);
               check("v5_vbstart_s", vblank_start_s, 0);
    goto(336); check("v6_vbstart_s", vblank_start_s, 1);
               check("v6_blank_s",   vga_blank_n_s, 0);
    goto(391); check("v6_vs_s",      vga_vs_s, 1);
    goto(392); check("v7_vs_s",      vga_vs_s, 0);
               check("v7_sync_n_s",  vga_sync_n_s, 0);
    goto(503); check("v8_vs_s",      vga_vs_s, 0);
    goto(504); check("v9_vs_s",      vga_vs_s, 1);
    goto(559); check("v9_vcount_s",  vcount_s, 9);
    goto(560);
    check("wrap_vcount_s", vcount_s, 0);
    check("wrap_fstart_s", frame_start_s, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("wrap_fcnt_s", frame_cnt_s, 1);
`else
    check("wrap_fcnt_s", frame_cnt_s, 0);
`endif

    // Default raster: visible h 0..639, hsync low h 656..751, line = 1600 cycles.
    goto(1279); check("h639_blank_d", vga_blank_n_d, 1);
    goto(1280); check("h640_blank_d", vga_blank_n_d, 0);
    goto(1311); check("h655_hs_d",    vga_hs_d, 1);
    goto(1312); check("h656_hs_d",    vga_hs_d, 0);
    goto(1503); check("h751_hs_d",    vga_hs_d, 0);
    goto(1504); check("h752_hs_d",    vga_hs_d, 1);
    goto(1598); check("h799_hcount_d", hcount_d, 799);
    goto(1600);
    check("line1_hcount_d", hcount_d, 0);
    check("line1_vcount_d", vcount_d, 1);
    check("line1_lstart_d", line_start_d, 1);

    goto(1700);
    check("k1700_hcount_s", hcount_s, 5);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("three_frames_fcnt_s", frame_cnt_s, 3);
`else
    check("three_frames_fcnt_s", frame_cnt_s, 0);
`endif

    // Enable gap of 5 cycles mid-line.
    enable = 1'b0;
    #1;
    check("gap_blank_s",  vga_blank_n_s, 0);
    check("gap_hs_d",     vga_hs_d, 1);
    tick(); tick(); tick(); tick(); tick();
    check("gap_hcount_s", hcount_s, 0);
    check("gap_vcount_s", vcount_s, 0);
    check("gap_hcount_d", hcount_d, 0);
    check("gap_vcount_d", vcount_d, 0);
    check("gap_fstart_s", frame_start_s, 0);
    check("gap_pix_en_s", pix_en_s, 0);
    enable = 1'b1;
    #1;
    cyc = 0;
    check("resume_fstart_s", frame_start_s, 1);
    check("resume_fstart_d", frame_start_d, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("resume_fcnt_s", frame_cnt_s, 3);
    goto(10);
    force dut_s.frame_cnt = 16'hFFFF;
    tick();
    release dut_s.frame_cnt;
    check("forced_fcnt_s", frame_cnt_s, 16'hFFFF);
    goto(560);
    check("rollover_fcnt_s", frame_cnt_s, 0);
`else
    goto(560);
    check("nomacro_fcnt_s", frame_cnt_s, 0);
`endif
    check("resume_wrap_fstart_s", frame_start_s, 1);

    // Mid-line reset with no clock edge in between.
    goto(1000);
    check("pre_rst_hcount_d", hcount_d, 500);
    check("pre_rst_hs_s",     vga_hs_s, 1);
    check("pre_rst_vs_s",     vga_vs_s, 0);
    reset = 1'b1;
    #2;
    check("async_rst_hcount_d", hcount_d, 0);
    check("async_rst_vcount_s", vcount_s, 0);
    check("async_rst_hs_s",     vga_hs_s, 0);
    check("async_rst_vs_s",     vga_vs_s, 1);
    check("async_rst_blank_d",  vga_blank_n_d, 0);
    check("async_rst_vclk_d",   vga_clk_d, 0);
    check("async_rst_lstart_s", line_start_s, 0);
    check("async_rst_fcnt_s",   frame_cnt_s, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
